// File: rtl/rfid_seq_pkg.sv
// Shared opcodes, FSM state codes and instruction-field layout helpers for the
// RFID Wishbone bus sequencer.
package rfid_seq_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [2:0] OP_HALT  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_POLL  = 3'd3;
    localparam logic [2:0] OP_JUMP  = 3'd4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_BUS   = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // Slave-select width: at least one bit even for a single slave.
    function automatic int unsigned sel_width(input int unsigned n_slaves);
        return (n_slaves > 1) ? $clog2(n_slaves) : 1;
    endfunction

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    // Word layout MSB->LSB: op | cs | sel | adr | dat
    function automatic int unsigned instr_width(input int unsigned n_cs, input int unsigned sel_w,
                                                input int unsigned addr_w, input int unsigned data_w);
        return OP_W + n_cs + sel_w + addr_w + data_w;
    endfunction

    function automatic int unsigned adr_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned sel_lsb(input int unsigned addr_w, input int unsigned data_w);
        return data_w + addr_w;
    endfunction

    function automatic int unsigned cs_lsb(input int unsigned sel_w, input int unsigned addr_w,
                                           input int unsigned data_w);
        return data_w + addr_w + sel_w;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned n_cs, input int unsigned sel_w,
                                           input int unsigned addr_w, input int unsigned data_w);
        return data_w + addr_w + sel_w + n_cs;
    endfunction

endpackage

// File: rtl/rfid_seq_prog_mem.sv
// Program store for the bus sequencer: synchronous write, combinational read.
// Contents are deliberately not reset so a program survives a sequencer reset.
module rfid_seq_prog_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 17,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rfid_bus_sequencer.sv
// Wishbone bus-master sequencer: runs a loaded program of WRITE/READ/POLL/JUMP/
// HALT words against N slaves, with per-instruction ack timeout and bounded
// polling. Drives slave strobe, return-mux select and SPI chip selects.
module rfid_bus_sequencer
    import rfid_seq_pkg::*;
#(
    parameter int unsigned N_SLAVES   = 2,
    parameter int unsigned N_CS       = 2,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned MAX_POLL   = 15,
    localparam int unsigned SEL_W     = sel_width(N_SLAVES),
    localparam int unsigned PC_W      = $clog2(PROG_DEPTH),
    localparam int unsigned INSTR_W   = instr_width(N_CS, SEL_W, ADDR_W, DATA_W)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                prog_we,
    input  logic [PC_W-1:0]     prog_addr,
    input  logic [INSTR_W-1:0]  prog_data,
    input  logic                start,
    output logic                cyc_o,
    output logic [N_SLAVES-1:0] stb_o,
    output logic [ADDR_W-1:0]   adr_o,
    output logic                we_o,
    output logic [DATA_W-1:0]   dat_o,
    input  logic [DATA_W-1:0]   dat_i,
    input  logic                ack_i,
    output logic [SEL_W-1:0]    dat_i_sel,
    output logic [N_CS-1:0]     spi_cs,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   rd_data,
    output logic [PC_W-1:0]     pc_o
);

    localparam int unsigned ADR_LSB = adr_lsb(DATA_W);
    localparam int unsigned SEL_LSB = sel_lsb(ADDR_W, DATA_W);
    localparam int unsigned CS_LSB  = cs_lsb(SEL_W, ADDR_W, DATA_W);
    localparam int unsigned OP_LSB  = op_lsb(N_CS, SEL_W, ADDR_W, DATA_W);

    localparam int unsigned TMO_W   = cnt_width(TIMEOUT);
    localparam int unsigned POLL_W  = cnt_width(MAX_POLL);

    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLL);
    localparam logic [PC_W-1:0]   PC_LAST   = PC_W'(PROG_DEPTH - 1);

    logic [1:0]          state;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     pc_next;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [POLL_W-1:0]   poll_cnt;

    logic [2:0]          ir_op;
    logic [SEL_W-1:0]    ir_sel;
    logic [ADDR_W-1:0]   ir_adr;
    logic [DATA_W-1:0]   ir_dat;

    logic [N_CS-1:0]     cs_r;
    logic [SEL_W-1:0]    sel_r;
    logic                err_r;
    logic                done_r;
    logic [DATA_W-1:0]   rd_r;

    logic                mem_we;
    logic [INSTR_W-1:0]  word;
    logic [2:0]          w_op;
    logic [N_CS-1:0]     w_cs;
    logic [SEL_W-1:0]    w_sel;
    logic [ADDR_W-1:0]   w_adr;
    logic [DATA_W-1:0]   w_dat;
    logic                poll_hit;

    // The program may only be rewritten while the sequencer is stopped.
    assign mem_we = prog_we && (state == S_IDLE);

    rfid_seq_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .WIDTH (INSTR_W),
        .AW    (PC_W)
    ) u_prog_mem (
        .clk_i (clk_i),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (word)
    );

    assign w_op  = word[OP_LSB  +: OP_W];
    assign w_cs  = word[CS_LSB  +: N_CS];
    assign w_sel = word[SEL_LSB +: SEL_W];
    assign w_adr = word[ADR_LSB +: ADDR_W];
    assign w_dat = word[0       +: DATA_W];

    assign pc_next  = (pc == PC_LAST) ? '0 : pc + 1'b1;
    assign poll_hit = |(dat_i & ir_dat);

    // Sequencer FSM, program counter, timers and status registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            pc       <= '0;
            tmo_cnt  <= '0;
            poll_cnt <= '0;
            ir_op    <= OP_HALT;
            ir_sel   <= '0;
            ir_adr   <= '0;
            ir_dat   <= '0;
            cs_r     <= '1;
            sel_r    <= '0;
            err_r    <= 1'b0;
            done_r   <= 1'b0;
            rd_r     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A same-cycle program write takes priority over start.
                    if (start && !prog_we) begin
                        pc       <= '0;
                        err_r    <= 1'b0;
                        poll_cnt <= '0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    tmo_cnt <= '0;
                    ir_op   <= w_op;
                    ir_sel  <= w_sel;
                    ir_adr  <= w_adr;
                    ir_dat  <= w_dat;
                    case (w_op)
                        OP_WRITE, OP_READ, OP_POLL: begin
                            cs_r  <= w_cs;
                            sel_r <= w_sel;
                            state <= S_BUS;
                        end
                        OP_JUMP: begin
                            pc <= w_dat[PC_W-1:0];
                        end
                        default: begin
                            done_r <= 1'b1;
                            state  <= S_IDLE;
                        end
                    endcase
                end
                S_BUS: begin
                    if (ack_i) begin
                        state <= S_GAP;
                        if (ir_op != OP_WRITE) begin
                            rd_r <= dat_i;
                        end
                        if (ir_op == OP_POLL) begin
                            if (poll_hit) begin
                                pc       <= pc_next;
                                poll_cnt <= '0;
                            end else if (poll_cnt == POLL_LAST) begin
                                err_r <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                poll_cnt <= poll_cnt + 1'b1;
                            end
                        end else begin
                            pc <= pc_next;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_r <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // One-hot slave strobe, only while a bus cycle is open
    always_comb begin
        stb_o = '0;
        if (cyc_o && (int'(ir_sel) < N_SLAVES)) begin
            stb_o[ir_sel] = 1'b1;
        end
    end

    assign cyc_o     = (state == S_BUS);
    assign adr_o     = cyc_o ? ir_adr : '0;
    assign dat_o     = cyc_o ? ir_dat : '0;
    assign we_o      = cyc_o && (ir_op == OP_WRITE);
    assign dat_i_sel = sel_r;
    assign spi_cs    = cs_r;
    assign busy      = (state != S_IDLE);
    assign done      = done_r;
    assign err       = err_r;
    assign rd_data   = rd_r;
    assign pc_o      = pc;

endmodule

// File: tb/tb_rfid_bus_sequencer.sv
// Scoreboard bench for rfid_bus_sequencer: directed programs, a behavioural
// Wishbone slave that checks each acknowledged transfer against a queue.
module tb_rfid_bus_sequencer;

    localparam int unsigned PC_W    = 4;
    localparam int unsigned INSTR_W = 17;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b0;
    logic               prog_we = 1'b0;
    logic [PC_W-1:0]    prog_addr = '0;
    logic [INSTR_W-1:0] prog_data = '0;
    logic               start = 1'b0;
    logic               cyc_o;
    logic [1:0]         stb_o;
    logic [2:0]         adr_o;
    logic               we_o;
    logic [7:0]         dat_o;
    logic [7:0]         dat_i = '0;
    logic               ack_i = 1'b0;
    logic               dat_i_sel;
    logic [1:0]         spi_cs;
    logic               busy;
    logic               done;
    logic               err;
    logic [7:0]         rd_data;
    logic [PC_W-1:0]    pc_o;

    rfid_bus_sequencer #(
        .N_SLAVES   (2),
        .N_CS       (2),
        .ADDR_W     (3),
        .DATA_W     (8),
        .PROG_DEPTH (16),
        .TIMEOUT    (5),
        .MAX_POLL   (3)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .adr_o     (adr_o),
        .we_o      (we_o),
        .dat_o     (dat_o),
        .dat_i     (dat_i),
        .ack_i     (ack_i),
        .dat_i_sel (dat_i_sel),
        .spi_cs    (spi_cs),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_data   (rd_data),
        .pc_o      (pc_o)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    // Slave behaviour knobs and observation counters
    int         wait_states = 0;
    int         ack_budget  = -1;
    logic [7:0] rdq [$];
    logic [16:0] expq [$];
    int         wcnt = 0;
    int         txn_cnt = 0;
    int         cyc_run = 0, last_burst = 0, bursts = 0;
    int         low_run = 0, last_low = 0;
    int         done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] mk(input logic [2:0] op, input logic [1:0] cs, input logic sel,
                                       input logic [2:0] adr, input logic [7:0] dat);
        return {op, cs, sel, adr, dat};
    endfunction

    // Expected transfer: {stb, adr, we, dat, dat_i_sel, spi_cs}
    function automatic logic [16:0] xp(input logic [1:0] stb, input logic [2:0] adr, input logic we,
                                       input logic [7:0] dat, input logic sel, input logic [1:0] cs);
        return {stb, adr, we, dat, sel, cs};
    endfunction

    // Slave model plus scoreboard monitor; also tracks burst / gap lengths
    always @(negedge clk_i) begin
        ack_i = 1'b0;
        if (cyc_o && ack_budget != 0 && wcnt == wait_states) begin
            ack_i = 1'b1;
            if (rdq.size() > 0) dat_i = rdq.pop_front();
            else dat_i = 8'h00;
            if (ack_budget > 0) ack_budget--;
            txn_cnt++;
            if (expq.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL sb_unexpected: got 0x%0h expected none",
                         {stb_o, adr_o, we_o, dat_o, dat_i_sel, spi_cs});
            end else begin
                check("sb_txn", 32'({stb_o, adr_o, we_o, dat_o, dat_i_sel, spi_cs}), 32'(expq.pop_front()));
            end
        end
        wcnt = cyc_o ? wcnt + 1 : 0;
        if (cyc_o) begin
            cyc_run++;
            if (low_run > 0) last_low = low_run;
            low_run = 0;
        end else begin
            if (cyc_run > 0) begin
                last_burst = cyc_run;
                bursts++;
            end
            cyc_run = 0;
            low_run++;
        end
        if (done) begin
            done_cnt++;
            check("done_with_busy_low", 32'(busy), 32'd0);
        end
    end

    task automatic load(input int unsigned a, input logic [16:0] w);
        @(negedge clk_i);
        prog_we = 1'b1; prog_addr = PC_W'(a); prog_data = w;
        @(negedge clk_i);
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk_i);
            if (!busy) break;
        end
        if (i == max_cyc) check({name, "_idle_timeout"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic wait_txn(input int target, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk_i);
            if (txn_cnt >= target) break;
        end
        if (i == max_cyc) check("txn_wait_timeout", 32'(txn_cnt), 32'(target));
    endtask

    task automatic wait_cyc(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk_i);
            if (cyc_o) break;
        end
        if (i == max_cyc) check("cyc_wait_timeout", 32'(cyc_o), 32'd1);
    endtask

    // Asynchronous reset applied between clock edges while a bus cycle is open
    task automatic reset_mid_bus(input string name);
        #1 rst_i = 1'b0;
        #1;
        check({name, "_cyc"},  32'(cyc_o),  32'd0);
        check({name, "_stb"},  32'(stb_o),  32'd0);
        check({name, "_busy"}, 32'(busy),   32'd0);
        check({name, "_cs"},   32'(spi_cs), 32'h3);
        check({name, "_pc"},   32'(pc_o),   32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, t0;

        repeat (3) @(negedge clk_i);
        check("rst_cyc",  32'(cyc_o),   32'd0);
        check("rst_stb",  32'(stb_o),   32'd0);
        check("rst_busy", 32'(busy),    32'd0);
        check("rst_done", 32'(done),    32'd0);
        check("rst_err",  32'(err),     32'd0);
        check("rst_cs",   32'(spi_cs),  32'h3);
        check("rst_rd",   32'(rd_data), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Single WRITE then HALT
        load(0, mk(3'd1, 2'b11, 1'b0, 3'd0, 8'h50));
        load(1, mk(3'd0, 2'b00, 1'b0, 3'd0, 8'h00));
        wait_states = 0; ack_budget = -1;
        expq.push_back(xp(2'b01, 3'd0, 1'b1, 8'h50, 1'b0, 2'b11));
        b0 = bursts; d0 = done_cnt;
        pulse_start();
        wait_idle("wr", 50);
        check("wr_bursts", 32'(bursts - b0),   32'd1);
        check("wr_len",    32'(last_burst),    32'd1);
        check("wr_done",   32'(done_cnt - d0), 32'd1);
        check("wr_err",    32'(err),           32'd0);
        check("wr_sb_empty", 32'(expq.size()), 32'd0);

        // READ from slave 1 with two wait states
        load(0, mk(3'd2, 2'b01, 1'b1, 3'd3, 8'h00));
        wait_states = 2;
        rdq.push_back(8'hA5);
        expq.push_back(xp(2'b10, 3'd3, 1'b0, 8'h00, 1'b1, 2'b01));
        b0 = bursts;
        pulse_start();
        wait_idle("rd", 50);
        check("rd_data",   32'(rd_data),      32'hA5);
        check("rd_len",    32'(last_burst),   32'd3);
        check("rd_bursts", 32'(bursts - b0),  32'd1);
        check("rd_err",    32'(err),          32'd0);

        // POLL mask 0x80: three misses then a hit
        load(0, mk(3'd3, 2'b10, 1'b0, 3'd5, 8'h80));
        wait_states = 0;
        rdq.push_back(8'h00); rdq.push_back(8'h00); rdq.push_back(8'h00); rdq.push_back(8'h80);
        for (int i = 0; i < 4; i++) expq.push_back(xp(2'b01, 3'd5, 1'b0, 8'h80, 1'b0, 2'b10));
        b0 = bursts; d0 = done_cnt;
        pulse_start();
        wait_idle("poll", 100);
        check("poll_bursts", 32'(bursts - b0),   32'd4);
        check("poll_err",    32'(err),           32'd0);
        check("poll_rd",     32'(rd_data),       32'h80);
        check("poll_done",   32'(done_cnt - d0), 32'd1);

        // POLL exhaustion with MAX_POLL=3: four misses then err
        for (int i = 0; i < 4; i++) begin
            rdq.push_back(8'h00);
            expq.push_back(xp(2'b01, 3'd5, 1'b0, 8'h80, 1'b0, 2'b10));
        end
        b0 = bursts; d0 = done_cnt;
        pulse_start();
        wait_idle("pollx", 100);
        check("pollx_bursts", 32'(bursts - b0),   32'd4);
        check("pollx_err",    32'(err),           32'd1);
        check("pollx_busy",   32'(busy),          32'd0);
        check("pollx_done",   32'(done_cnt - d0), 32'd0);
        check("pollx_sb_empty", 32'(expq.size()), 32'd0);

        // Ack timeout, TIMEOUT=5
        load(0, mk(3'd1, 2'b00, 1'b1, 3'd2, 8'h33));
        ack_budget = 0;
        pulse_start();
        wait_idle("tmo", 50);
        check("tmo_len", 32'(last_burst), 32'd5);
        check("tmo_err", 32'(err),        32'd1);
        ack_budget = -1;
        expq.push_back(xp(2'b10, 3'd2, 1'b1, 8'h33, 1'b1, 2'b00));
        pulse_start();
        check("tmo_err_cleared", 32'(err), 32'd0);
        wait_idle("tmo2", 50);
        check("tmo2_err", 32'(err), 32'd0);

        // WRITE + JUMP 0 loop, reset mid-bus, then re-run from intact memory
        load(0, mk(3'd1, 2'b01, 1'b0, 3'd1, 8'h11));
        load(1, mk(3'd4, 2'b00, 1'b0, 3'd0, 8'h00));
        ack_budget = 3;
        for (int i = 0; i < 3; i++) expq.push_back(xp(2'b01, 3'd1, 1'b1, 8'h11, 1'b0, 2'b01));
        t0 = txn_cnt;
        pulse_start();
        wait_txn(t0 + 3, 100);
        repeat (2) @(negedge clk_i);
        wait_cyc(20);
        reset_mid_bus("rst1");
        check("jump_gap", 32'(last_low), 32'd3);
        check("rst1_sb_empty", 32'(expq.size()), 32'd0);
        ack_budget = 2;
        for (int i = 0; i < 2; i++) expq.push_back(xp(2'b01, 3'd1, 1'b1, 8'h11, 1'b0, 2'b01));
        t0 = txn_cnt;
        pulse_start();
        wait_txn(t0 + 2, 100);
        repeat (2) @(negedge clk_i);
        wait_cyc(20);
        reset_mid_bus("rst2");
        check("rst2_sb_empty", 32'(expq.size()), 32'd0);

        // Program write while busy is ignored
        load(0, mk(3'd1, 2'b11, 1'b0, 3'd4, 8'h77));
        load(1, mk(3'd0, 2'b00, 1'b0, 3'd0, 8'h00));
        ack_budget = -1; wait_states = 3;
        expq.push_back(xp(2'b01, 3'd4, 1'b1, 8'h77, 1'b0, 2'b11));
        pulse_start();
        load(0, mk(3'd1, 2'b11, 1'b0, 3'd4, 8'h99));
        wait_idle("pwb", 50);
        wait_states = 0;
        expq.push_back(xp(2'b01, 3'd4, 1'b1, 8'h77, 1'b0, 2'b11));
        pulse_start();
        wait_idle("pwb2", 50);
        check("pwb_sb_empty", 32'(expq.size()), 32'd0);

        // start together with prog_we: no run
        b0 = bursts;
        @(negedge clk_i);
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = mk(3'd0, 2'b00, 1'b0, 3'd0, 8'h00); start = 1'b1;
        @(negedge clk_i);
        prog_we = 1'b0; start = 1'b0;
        check("startwe_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk_i);
        check("startwe_bursts", 32'(bursts - b0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
